// File: rtl/fifo_mem_param.sv
// fifo_mem_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags and overflow/underflow pulses.
// Optional feature macro: FIFO_FWFT_EN selects first-word-fall-through output.
// With the macro undefined, data_out is a registered read and rd_valid marks
// each popped word.
//
// Handshake: wr and rd are requests, not valid/ready pairs. A write is taken
// when the FIFO is not full, or when a read is taken in the same cycle. A read
// is taken only when the FIFO is not empty. A request that is not taken is
// dropped, and the matching error pulse appears for one cycle after the edge.
module fifo_mem_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic [AW:0]       fifo_count,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_almost_full,
  output logic              fifo_almost_empty,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   AF_C    = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_C    = (AW + 1)'(AE_LEVEL);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              rd_acc;
  logic              we;
  logic [AW:0]       count_next;

  // Acceptance and next occupancy; full/empty come from the count, never from
  // pointer comparison, so wrapped pointers need no extra bit.
  always_comb begin
    rd_acc     = rd & ~fifo_empty;
    we         = wr & (~fifo_full | rd_acc);
    count_next = fifo_count;
    case ({we, rd_acc})
      2'b10:   count_next = fifo_count + CNT_ONE;
      2'b01:   count_next = fifo_count - CNT_ONE;
      default: count_next = fifo_count;
    endcase
  end

  // Storage array: no reset; writes in a reset cycle are ignored.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem[wptr] <= data_in;
    end
  end

  // Pointers, count, registered flags and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr              <= '0;
      rptr              <= '0;
      fifo_count        <= '0;
      fifo_full         <= 1'b0;
      fifo_empty        <= 1'b1;
      fifo_almost_full  <= 1'b0;
      fifo_almost_empty <= 1'b1;
      fifo_overflow     <= 1'b0;
      fifo_underflow    <= 1'b0;
    end else begin
      if (we) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_acc) begin
        rptr <= rptr + PTR_ONE;
      end
      fifo_count        <= count_next;
      fifo_full         <= (count_next == DEPTH_C);
      fifo_empty        <= (count_next == '0);
      fifo_almost_full  <= (count_next >= AF_C);
      fifo_almost_empty <= (count_next <= AE_C);
      fifo_overflow     <= wr & ~we;
      fifo_underflow    <= rd & ~rd_acc;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is shown combinationally while the FIFO holds data; zero when
  // empty keeps the output free of uninitialised storage.
  always_comb begin
    data_out = fifo_empty ? '0 : mem[rptr];
    rd_valid = 1'b0;
  end
`else
  // Registered read: the popped word is presented for one cycle with rd_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        data_out <= mem[rptr];
      end
    end
  end
`endif

endmodule

// File: doc/fifo_mem_param.md
# fifo_mem_param

Parametrised synchronous FIFO: the next generation of the fixed 8-bit x 16 FIFO, with configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags, and defined behaviour for simultaneous read/write at the boundaries. All status outputs are registered and updated on the same edge as the pointers. It sits between a single-clock producer and consumer in the datapath and replaces the fixed FIFO wherever other sizes are needed.

## Interface
- DATA_W, 8, data word width in bits (>=1)
- DEPTH, 16, number of entries; power of two, >=4
- AF_LEVEL, DEPTH-2, almost-full asserts when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost-empty asserts when count <= AE_LEVEL (0..DEPTH-1)
- Derived: AW = $clog2(DEPTH); count width is AW+1

- clk  in  1  rising-edge clock, the only clock
- rst  in  1  reset; synchronous and active-high
- wr  in  1  write request
- rd  in  1  read request
- data_in  in  DATA_W  write data, sampled when a write is accepted
- data_out  out  DATA_W  read data (see Operation for mode)
- rd_valid  out  1  data_out holds a newly popped word (standard mode only)
- fifo_count  out  AW+1  current occupancy, 0..DEPTH
- fifo_full  out  1  count == DEPTH
- fifo_empty  out  1  count == 0
- fifo_almost_full  out  1  count >= AF_LEVEL
- fifo_almost_empty  out  1  count <= AE_LEVEL
- fifo_overflow  out  1  one-cycle pulse: write rejected
- fifo_underflow  out  1  one-cycle pulse: read rejected

## Operation
- Storage: DEPTH x DATA_W register array. The array is not reset.
- Pointers: wptr and rptr are each AW bits and wrap naturally from DEPTH-1 to 0. Full/empty are decided from fifo_count, not from pointer compare.
- Write acceptance: we = wr & (!fifo_full | rd_acc). A write into a full FIFO is accepted only when a read is accepted in the same cycle.
- Read acceptance: rd_acc = rd & !fifo_empty. A read on an empty FIFO is always rejected, even when a write is accepted in the same cycle.
- Count update: +1 on we only, -1 on rd_acc only, unchanged on both or neither.
- Error pulses:
  - fifo_overflow = 1 in the cycle after a cycle with wr & !we. Pointers, count and memory are unchanged.
  - fifo_underflow = 1 in the cycle after a cycle with rd & !rd_acc. data_out holds its previous value and rd_valid = 0.
- Flags: all flags are computed from the next-count value and registered, so they are exact in the cycle after the event. There is no lag of more than one edge.
- Standard mode (macro undefined):
  - On rd_acc, data_out <= mem[rptr] and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and data_out holds.
- Reset: while rst is high at a rising edge, the following values are loaded:
  - wptr = rptr = 0, fifo_count = 0
  - fifo_empty = 1, fifo_almost_empty = 1
  - fifo_full = 0, fifo_almost_full = 0
  - fifo_overflow = 0, fifo_underflow = 0
  - data_out = 0, rd_valid = 0
- Reset mid-operation discards all contents. A wr or rd in the reset cycle is ignored and raises no error pulse.

## Timing
- Write to visibility: write accepted at edge N; fifo_empty falls and fifo_count increments after edge N. A read can be accepted in cycle N+1.
- Standard-mode read latency: rd accepted in cycle N gives data_out/rd_valid valid after edge N, for one cycle.
- Full throughput: one write and one read per cycle are sustained indefinitely, including at count 0 (after the first write) and at count DEPTH.
- Error pulses are exactly one cycle per offending request cycle. Back-to-back offending cycles give a continuously high pulse.

## Configuration
- FIFO_FWFT_EN: first-word-fall-through mode.
  - Defined: data_out continuously shows mem[rptr] whenever fifo_empty = 0. rd pops the shown word, and the next word appears after the same edge. rd_valid is tied to 0. A written word into an empty FIFO appears on data_out one cycle after the write edge. data_out is don't-care while empty.
  - Undefined: standard registered-read behaviour as above.
  - Acceptance, flags and count are identical in both modes.

## Test plan
- Reset then idle (default params): fifo_empty = 1, fifo_almost_empty = 1, fifo_count = 0, data_out = 0, all other outputs 0. Assert rst mid-fill at count 5: the next cycle shows count 0 and empty = 1.
- Fill 16 words 0x00..0x0F, then one extra wr: fifo_full = 1 and almost_full asserted from count 14. One overflow pulse follows, count stays 16, and draining returns 0x00..0x0F in order, each with rd_valid.
- Read on empty with a simultaneous wr of 0xA5: underflow pulse, count becomes 1. A following rd returns 0xA5.
- At full, wr = rd = 1 for 40 cycles with an incrementing pattern: no overflow, count stays 16, and the output sequence is correct across multiple pointer wraps.
- DATA_W = 32, DEPTH = 64, AF_LEVEL = 60, AE_LEVEL = 3: almost_empty falls at count 4, almost_full rises at count 60, and full is reached at count 64.
- With FIFO_FWFT_EN defined: write 0x11 then 0x22, and data_out = 0x11 one cycle after the first write edge. rd changes data_out to 0x22 after the edge. A second rd sets empty = 1.
